mtimer_tick: RTL and testbench
==============================

Name: mtimer_tick

Overview:
- Machine-timer peripheral for the three-stage RISC-V core. Sits directly downstream of clock_div.
- Consumes clock_div's divided output (1 MHz from 100 MHz) as a time-base level. Rising edges of that level advance a 64-bit mtime counter.
- Compares mtime against a 64-bit mtimecmp and drives the machine timer interrupt into the core.
- Registers are memory-mapped on the core's 32-bit data bus; whole block runs on the system clock.

Parameters:
- STEP, 1, 64-bit increment added to mtime per detected tick.
- CMP_RESET, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp (no IRQ out of reset).
- ADDR_W, 5, byte-address width of register window.

Ports:
- clk_i  in  1  system clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- tick_i  in  1  time-base level from clock_div clk_o; synchronous to clk_i.
- sel_i  in  1  bus select; access valid this cycle.
- we_i  in  1  1 = write, 0 = read (qualified by sel_i).
- addr_i  in  ADDR_W  byte address; word aligned, bits [1:0] ignored.
- wdata_i  in  32  write data.
- rdata_o  out  32  read data, registered.
- irq_o  out  1  machine timer interrupt (MTIP), level.

Behaviour:
- Register map:
  - 0x00 MTIME_LO
  - 0x04 MTIME_HI
  - 0x08 MTIMECMP_LO
  - 0x0C MTIMECMP_HI
  - 0x10 CTRL: bit0 EN, bit1 IRQ_EN, bit2 PEND (read-only); other bits read 0.
- Unmapped addresses: read 0, writes ignored.
- Reset values:
  - mtime = 0, mtimecmp = CMP_RESET, CTRL = 0.
  - tick_q = 0, rdata_o = 0, irq_o = 0.
- Tick detection:
  - tick_q <= tick_i every cycle.
  - rise = tick_i & ~tick_q.
  - Exactly one rise per tick_i period, regardless of its high time.
- Counting:
  - On the clock edge where rise && EN: mtime <= mtime + STEP, modulo 2^64.
  - Carry from lo to hi in the same cycle.
  - All-ones + 1 wraps to 0, no flag.
  - With EN = 0, rises are discarded, not queued.
- Writes (sel_i && we_i):
  - Take effect on that clock edge; zero wait states.
  - A write to MTIME_LO or MTIME_HI on the same edge as a rise wins. The written half takes wdata_i, the other half keeps its old value, and no increment occurs that cycle.
- Reads (sel_i && !we_i):
  - rdata_o updates on the edge, one-cycle latency.
  - Returns values as they were before that edge's updates.
  - Otherwise rdata_o holds its last value.
- Compare:
  - PEND = (mtime >= mtimecmp), unsigned 64-bit, computed from registered state.
  - irq_o <= PEND && IRQ_EN, registered.
  - irq_o rises one cycle after the state satisfying the compare is visible.
  - irq_o stays high until mtimecmp is raised, mtime wraps, or IRQ_EN is cleared.
  - Level only, no sticky bit; writing CTRL bit2 has no effect.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). The first rise after reset release is counted.

Optional Feature:
- Macro: MTIMER_HI_SNAPSHOT_EN.
- Defined:
  - A read of MTIME_LO also captures mtime[63:32] into a 32-bit shadow register (reset 0).
  - A read of MTIME_HI returns the shadow.
  - A lo-then-hi read pair is therefore atomic across a lo-to-hi carry.
- Not defined: no shadow register; MTIME_HI reads return live mtime[63:32].

Decomposition:
- Package mtimer_pkg:
  - Address constants MTIME_LO_A, MTIME_HI_A, MTIMECMP_LO_A, MTIMECMP_HI_A, CTRL_A.
  - CTRL bit indices CTRL_EN, CTRL_IRQ_EN, CTRL_PEND.
  - typedef logic [63:0] mtime_t.
- One sub-module: tick_rise_detect (clk_i, rst_i, tick_i -> rise_o), the tick_q flop plus edge logic.

Test Plan:
- Reset release, then drive tick_i from clock_div with CLOCK_SYS = 100e6 and CLOCK_OUT = 1e6, EN = 1: mtime increments exactly once per 100 clk_i cycles; after 1000 us, MTIME_LO reads 1000.
- EN = 0 for 5 tick periods, then EN = 1: mtime unchanged while disabled; counting resumes from the held value on the next rise.
- Write MTIME_LO = 32'hFFFF_FFFF and MTIME_HI = 0, then one rise: MTIME_LO = 0, MTIME_HI = 1. Separately, mtime = all ones plus one rise gives 0.
- Write MTIME_LO = 5 on the same edge as a rise, with mtime = 9: MTIME_LO reads 5, not 6 or 10.
- mtimecmp = 10, IRQ_EN = 1, count from 0:
  - PEND sets when mtime = 10; irq_o is high one cycle later.
  - Write MTIMECMP_LO = 100: irq_o drops one cycle after PEND clears.
  - With IRQ_EN = 0, irq_o stays 0 while PEND reads 1.
- With MTIMER_HI_SNAPSHOT_EN, mtime = 0x0000_0000_FFFF_FFFF: read lo, rise, read hi. Hi returns 0 with the macro and 1 without.

Source files
------------

// File: rtl/mtimer_pkg.sv
// Shared definitions for the machine-timer block: register offsets, CTRL bit
// positions and the 64-bit time type.
package mtimer_pkg;
  typedef logic [63:0] mtime_t;

  localparam logic [31:0] MTIME_LO_A    = 32'h00;
  localparam logic [31:0] MTIME_HI_A    = 32'h04;
  localparam logic [31:0] MTIMECMP_LO_A = 32'h08;
  localparam logic [31:0] MTIMECMP_HI_A = 32'h0C;
  localparam logic [31:0] CTRL_A        = 32'h10;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_PEND   = 2;
endpackage

// File: rtl/tick_rise_detect.sv
// One-cycle pulse on each rising edge of the clk_i-synchronous time-base level.
module tick_rise_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  output logic rise_o
);
  logic tick_q;

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) tick_q <= 1'b0;
    else       tick_q <= tick_i;

  assign rise_o = tick_i & ~tick_q;
endmodule

// File: rtl/mtimer_tick.sv
// Memory-mapped 64-bit mtime/mtimecmp with level MTIP output.
// Optional MTIMER_HI_SNAPSHOT_EN: MTIME_LO reads latch mtime[63:32] for the next MTIME_HI read.
module mtimer_tick
  import mtimer_pkg::*;
#(
  parameter mtime_t STEP      = 64'd1,
  parameter mtime_t CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int     ADDR_W    = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tick_i,
  input  logic              sel_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              irq_o
);
  logic        rise;
  mtime_t      mtime, mtimecmp;
  logic        en, irq_en, pend;
  logic [31:0] addr, rd_val, ctrl_rd, hi_rd;
  logic        wr, rd, mtime_wr;

  tick_rise_detect u_rise (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_i (tick_i),
    .rise_o (rise)
  );

  assign addr     = 32'(addr_i) & ~32'h3;
  assign wr       = sel_i & we_i;
  assign rd       = sel_i & ~we_i;
  assign mtime_wr = wr & ((addr == MTIME_LO_A) | (addr == MTIME_HI_A));
  assign pend     = (mtime >= mtimecmp);

  // A bus write to either mtime half overrides that edge's increment entirely.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      mtime    <= '0;
      mtimecmp <= CMP_RESET;
      en       <= 1'b0;
      irq_en   <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      if (mtime_wr) begin
        if (addr == MTIME_LO_A) mtime[31:0]  <= wdata_i;
        else                    mtime[63:32] <= wdata_i;
      end else if (rise && en) begin
        mtime <= mtime + STEP;
      end
      if (wr) begin
        case (addr)
          MTIMECMP_LO_A: mtimecmp[31:0]  <= wdata_i;
          MTIMECMP_HI_A: mtimecmp[63:32] <= wdata_i;
          CTRL_A: begin
            en     <= wdata_i[CTRL_EN];
            irq_en <= wdata_i[CTRL_IRQ_EN];
          end
          default: ;
        endcase
      end
      irq_o <= pend & irq_en;
    end

`ifdef MTIMER_HI_SNAPSHOT_EN
  logic [31:0] hi_shadow;

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i)                          hi_shadow <= '0;
    else if (rd && addr == MTIME_LO_A)  hi_shadow <= mtime[63:32];

  assign hi_rd = hi_shadow;
`else
  assign hi_rd = mtime[63:32];
`endif

  always_comb begin
    ctrl_rd            = '0;
    ctrl_rd[CTRL_EN]     = en;
    ctrl_rd[CTRL_IRQ_EN] = irq_en;
    ctrl_rd[CTRL_PEND]   = pend;
  end

  always_comb begin
    rd_val = '0;
    case (addr)
      MTIME_LO_A:    rd_val = mtime[31:0];
      MTIME_HI_A:    rd_val = hi_rd;
      MTIMECMP_LO_A: rd_val = mtimecmp[31:0];
      MTIMECMP_HI_A: rd_val = mtimecmp[63:32];
      CTRL_A:        rd_val = ctrl_rd;
      default:       rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i)   rdata_o <= '0;
    else if (rd) rdata_o <= rd_val;
endmodule

// File: tb/tb_mtimer_tick.sv
// Directed bench for mtimer_tick: bus reads go through an expected-value queue.
module tb_mtimer_tick;
  logic        clk = 1'b0, rst = 1'b1, tick = 1'b0;
  logic        sel = 1'b0, we = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wdata = '0, rdata;
  logic        irq;

  int          n_cmp = 0, n_err = 0, ph = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

`ifdef MTIMER_HI_SNAPSHOT_EN
  localparam logic [31:0] SNAP_HI = 32'd0;
`else
  localparam logic [31:0] SNAP_HI = 32'd1;
`endif

  mtimer_tick dut (
    .clk_i (clk), .rst_i (rst), .tick_i (tick), .sel_i (sel), .we_i (we),
    .addr_i (addr), .wdata_i (wdata), .rdata_o (rdata), .irq_o (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
    sel = 1'b1; we = 1'b0; addr = a;
    exp_q.push_back(exp); tag_q.push_back(tag);
    @(negedge clk);
    sel = 1'b0;
    chk(tag_q.pop_front(), rdata, exp_q.pop_front());
  endtask

  task automatic pulse();
    tick = 1'b0; @(negedge clk);
    tick = 1'b1; @(negedge clk);
    tick = 1'b0; @(negedge clk);
  endtask

  // clock_div model: 100 MHz -> 1 MHz, 50% duty.
  task automatic run_div(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick = (ph >= 50);
      ph = (ph + 1) % 100;
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    bus_rd(5'h00, 32'h0, "rst_mtime_lo");
    bus_rd(5'h04, 32'h0, "rst_mtime_hi");
    bus_rd(5'h08, 32'hFFFF_FFFF, "rst_cmp_lo");
    bus_rd(5'h0C, 32'hFFFF_FFFF, "rst_cmp_hi");
    bus_rd(5'h10, 32'h0, "rst_ctrl");
    bus_wr(5'h18, 32'hDEAD_BEEF);
    bus_rd(5'h18, 32'h0, "unmapped_rd");
    bus_rd(5'h0B, 32'hFFFF_FFFF, "low_bits_ignored");

    // Counting from the divided time base.
    bus_wr(5'h10, 32'h1);
    bus_rd(5'h10, 32'h1, "ctrl_en");
    for (int k = 1; k <= 10; k++) begin
      run_div(100);
      bus_rd(5'h00, 32'(k), $sformatf("div_count_%0d", k));
    end

    // Disabled: rises dropped, not queued.
    bus_wr(5'h10, 32'h0);
    run_div(500);
    bus_rd(5'h00, 32'd10, "en0_held");
    bus_wr(5'h10, 32'h1);
    pulse();
    bus_rd(5'h00, 32'd11, "en1_resume");

    // Carry and wrap.
    bus_wr(5'h00, 32'hFFFF_FFFF);
    bus_wr(5'h04, 32'h0);
    pulse();
    bus_rd(5'h00, 32'h0, "carry_lo");
    bus_rd(5'h04, 32'h1, "carry_hi");
    bus_wr(5'h00, 32'hFFFF_FFFF);
    bus_wr(5'h04, 32'hFFFF_FFFF);
    pulse();
    bus_rd(5'h00, 32'h0, "wrap_lo");
    bus_rd(5'h04, 32'h0, "wrap_hi");

    // Write to an mtime half on the same edge as a rise.
    bus_wr(5'h00, 32'd9);
    tick = 1'b0; @(negedge clk);
    tick = 1'b1; bus_wr(5'h00, 32'd5);
    tick = 1'b0; @(negedge clk);
    bus_rd(5'h00, 32'd5, "wr_lo_wins");
    bus_rd(5'h04, 32'd0, "wr_lo_hi_kept");
    bus_wr(5'h00, 32'hFFFF_FFFF);
    tick = 1'b1; bus_wr(5'h04, 32'd7);
    tick = 1'b0; @(negedge clk);
    bus_rd(5'h00, 32'hFFFF_FFFF, "wr_hi_lo_kept");
    bus_rd(5'h04, 32'd7, "wr_hi_wins");

    // Compare and interrupt.
    bus_wr(5'h00, 32'h0);
    bus_wr(5'h04, 32'h0);
    bus_wr(5'h0C, 32'h0);
    bus_wr(5'h08, 32'd10);
    bus_wr(5'h10, 32'h3);
    for (int k = 0; k < 9; k++) pulse();
    bus_rd(5'h10, 32'h3, "ctrl_at_9");
    chk("irq_at_9", {31'b0, irq}, 32'h0);
    tick = 1'b0; @(negedge clk);
    tick = 1'b1; @(negedge clk);
    chk("irq_lag", {31'b0, irq}, 32'h0);
    tick = 1'b0; @(negedge clk);
    chk("irq_set", {31'b0, irq}, 32'h1);
    bus_rd(5'h10, 32'h7, "ctrl_pend");
    bus_wr(5'h08, 32'd100);
    chk("irq_hold_1cyc", {31'b0, irq}, 32'h1);
    bus_rd(5'h10, 32'h3, "pend_clear");
    chk("irq_drop", {31'b0, irq}, 32'h0);
    bus_wr(5'h10, 32'h1);
    bus_wr(5'h08, 32'd5);
    bus_rd(5'h10, 32'h5, "pend_no_irqen");
    chk("irq_masked", {31'b0, irq}, 32'h0);
    bus_wr(5'h08, 32'd100);
    bus_wr(5'h10, 32'h7);
    bus_rd(5'h10, 32'h3, "pend_not_writable");
    chk("irq_after_pend_wr", {31'b0, irq}, 32'h0);

    // lo-then-hi read across a carry.
    bus_wr(5'h00, 32'hFFFF_FFFF);
    bus_wr(5'h04, 32'h0);
    bus_rd(5'h00, 32'hFFFF_FFFF, "snap_lo");
    pulse();
    bus_rd(5'h04, SNAP_HI, "snap_hi");

    // Asynchronous reset mid-operation.
    bus_rd(5'h08, 32'd100, "pre_rst_cmp");
    chk("irq_pre_rst", {31'b0, irq}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rdata", rdata, 32'h0);
    chk("async_rst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus_rd(5'h08, 32'hFFFF_FFFF, "rst2_cmp_lo");
    bus_rd(5'h00, 32'h0, "rst2_mtime_lo");
    bus_wr(5'h10, 32'h1);
    pulse();
    bus_rd(5'h00, 32'h1, "first_rise_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
